// File: rtl/mult_issue_queue_pkg.sv
// Shared types and defaults for the multiplier issue queue.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] a;
        logic [DEFAULT_WIDTH-1:0] b;
    } op_pair_t;

endpackage

// File: rtl/mult_issue_queue_if.sv
// Producer, multiplier and consumer handshakes of the issue queue.
interface mult_issue_queue_if import mult_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               op_vld;
    logic               op_rdy;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic               mul_vld;
    logic [2*WIDTH-1:0] mul_res;
    logic               mul_rdy;
    logic [WIDTH-1:0]   out_a;
    logic [WIDTH-1:0]   out_b;
    logic [2*WIDTH-1:0] out_res;
    logic               out_vld;
    logic               out_rdy;
    logic               busy;

    // The issue queue itself.
    modport slave (
        input  op_a, op_b, op_vld, mul_res, mul_rdy, out_rdy,
        output op_rdy, mul_a, mul_b, mul_vld, out_a, out_b, out_res, out_vld, busy
    );

    // Whatever surrounds the queue: producer, multiplier and consumer.
    modport master (
        output op_a, op_b, op_vld, mul_res, mul_rdy, out_rdy,
        input  op_rdy, mul_a, mul_b, mul_vld, out_a, out_b, out_res, out_vld, busy
    );
endinterface

// File: rtl/mult_op_fifo.sv
// Small synchronous FIFO holding operand pairs; head is visible combinationally.
module mult_op_fifo import mult_pkg::*; #(
    parameter type item_t = op_pair_t,
    parameter int  DEPTH  = DEFAULT_DEPTH,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  item_t       wdata,
    input  logic        pop,
    output item_t       rdata,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);
    item_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/mult_issue_queue.sv
// Feeds queued operand pairs to an external sequential multiplier and
// presents each product, with its operands, on a valid/ready output.
//
// state | meaning
// IDLE  | waiting for a queued pair and an idle multiplier; pops on exit
// ISSUE | single-cycle start pulse on mul_vld
// BUSY  | waiting for the multiplier to drop mul_rdy
// DONE  | waiting for mul_rdy and a free output register to capture
module mult_issue_queue import mult_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input logic             clk,
    input logic             rst,
    mult_issue_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pair_t;

    state_t             state;
    state_t             state_nxt;
    pair_t              fifo_in;
    pair_t              head;
    logic [AW:0]        fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               capture;
    logic [WIDTH-1:0]   mul_a_q;
    logic [WIDTH-1:0]   mul_b_q;
    logic [WIDTH-1:0]   out_a_q;
    logic [WIDTH-1:0]   out_b_q;
    logic [2*WIDTH-1:0] out_res_q;
    logic               out_vld_q;

    assign fifo_in.a = bus.op_a;
    assign fifo_in.b = bus.op_b;

    mult_op_fifo #(
        .item_t (pair_t),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.op_vld),
        .wdata (fifo_in),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state, FIFO pop and output capture strobe.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && bus.mul_rdy) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = BUSY;
            BUSY: begin
                if (!bus.mul_rdy) state_nxt = DONE;
            end
            DONE: begin
                if (bus.mul_rdy && (!out_vld_q || bus.out_rdy)) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands double as the tags of the job in flight; held until the next pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else if (pop) begin
            mul_a_q <= head.a;
            mul_b_q <= head.b;
        end
    end

    // Output register: a capture in the handshake cycle keeps out_vld high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_a_q   <= '0;
            out_b_q   <= '0;
            out_res_q <= '0;
            out_vld_q <= 1'b0;
        end else if (capture) begin
            out_a_q   <= mul_a_q;
            out_b_q   <= mul_b_q;
            out_res_q <= bus.mul_res;
            out_vld_q <= 1'b1;
        end else if (out_vld_q && bus.out_rdy) begin
            out_vld_q <= 1'b0;
        end
    end

    assign bus.op_rdy  = !fifo_full;
    assign bus.mul_a   = mul_a_q;
    assign bus.mul_b   = mul_b_q;
    assign bus.mul_vld = (state == ISSUE);
    assign bus.out_a   = out_a_q;
    assign bus.out_b   = out_b_q;
    assign bus.out_res = out_res_q;
    assign bus.out_vld = out_vld_q;
    assign bus.busy    = (fifo_count != '0) || (state != IDLE) || out_vld_q;
endmodule

// File: doc/mult_issue_queue.md
Name: mult_issue_queue

Overview:
- Upstream feeder and result collector for the sequential Multiplier block.
- Buffers operand pairs from a valid/ready producer in a small FIFO and issues them one at a time over the Multiplier's in_vld/res_rdy protocol.
- Captures each product into an output register presented on a valid/ready consumer interface.
- Decouples bursty producers from the multi-cycle multiplier; the Multiplier instance sits outside this block.

Parameters:
- WIDTH, 8, operand width; product width is 2*WIDTH.
- DEPTH, 4, operand FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- op_a  input  WIDTH  operand A from producer.
- op_b  input  WIDTH  operand B from producer.
- op_vld  input  1  producer offers a pair.
- op_rdy  output  1  FIFO not full; pair accepted when op_vld && op_rdy.
- mul_a  output  WIDTH  operand A to Multiplier in_a.
- mul_b  output  WIDTH  operand B to Multiplier in_b.
- mul_vld  output  1  one-cycle start pulse to Multiplier in_vld.
- mul_res  input  2*WIDTH  Multiplier res.
- mul_rdy  input  1  Multiplier res_rdy: high = idle, res valid.
- out_a  output  WIDTH  operand A of the presented result.
- out_b  output  WIDTH  operand B of the presented result.
- out_res  output  2*WIDTH  product.
- out_vld  output  1  result register full.
- out_rdy  input  1  consumer takes the result when out_vld && out_rdy.
- busy  output  1  FIFO non-empty, FSM not IDLE, or out_vld high.

Behaviour:
- Reset (async, any cycle, including mid-multiply): FIFO emptied, FSM to IDLE, out_vld=0, mul_vld=0, out_a/out_b/out_res=0, mul_a/mul_b=0, op_rdy=1, busy=0.
- An in-flight multiplication is abandoned; its later result is ignored.
- FIFO:
  - Write on op_vld && op_rdy.
  - Pop when the FSM leaves IDLE.
  - Simultaneous push and pop while full is not allowed: op_rdy is low when full.
  - Simultaneous push and pop at any other occupancy keeps the count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE:
    - If the FIFO is non-empty and mul_rdy=1, go to ISSUE.
    - On the same edge, pop the head into mul_a/mul_b and into the pending-tag registers.
  - ISSUE:
    - mul_vld=1 for exactly this cycle.
    - Go to BUSY.
  - BUSY:
    - Wait for mul_rdy=0, then go to DONE.
    - The Multiplier drops res_rdy within 1 cycle of accepting in_vld.
    - Stay in BUSY while mul_rdy=1 after ISSUE.
  - DONE:
    - Wait for mul_rdy=1 and the output register free.
    - "Free" means out_vld=0, or out_vld && out_rdy this cycle.
    - When both hold, capture mul_res and the tags into out_*, set out_vld=1, and go to IDLE.
- mul_a/mul_b hold their value from IDLE exit until the next issue, as the Multiplier samples them with in_vld.
- Output register:
  - out_vld clears on handshake unless a new capture occurs in the same cycle; a same-cycle capture wins and out_vld stays 1.
  - out_* are stable while out_vld && !out_rdy.
- Throughput:
  - At most one multiplication in flight.
  - Minimum issue-to-capture latency is 3 cycles plus the Multiplier latency.
  - IDLE adds 1 cycle between back-to-back jobs.
- Back-pressure: if out_rdy is held low, the FSM waits in DONE with the result available on mul_res, and the FIFO fills until op_rdy=0.
- Results appear in FIFO order; no reordering or dropping.

Decomposition:
- Package mult_pkg:
  - state_t enum {IDLE, ISSUE, BUSY, DONE};
  - default WIDTH/DEPTH localparams;
  - op_pair_t struct {a, b}.
- One sub-module, mult_op_fifo: a parameterised synchronous FIFO of op_pair_t with count, full, empty and async reset.
- The FSM and output register live in mult_issue_queue.

Test Plan:
- Single job: push (12, 13) with out_rdy=1 → exactly one mul_vld pulse with mul_a=12, mul_b=13; out_vld rises with out_res=156, out_a=12, out_b=13.
- Burst: push (255,255), (0,77), (3,5), (200,2) back-to-back → op_rdy stays high; results 65025, 0, 15, 400 in order.
- Full FIFO: out_rdy=0, push 6 pairs → 1 captured, 1 held in DONE, 4 in FIFO, op_rdy=0; raise out_rdy → all 6 drain in order with no duplicates.
- Simultaneous events: out_vld=1, out_rdy=1 in the capture cycle → out_vld stays 1 and out_res updates to the new product with no gap. Separately, push while popping at count=2 → count stays 2.
- Reset mid-operation: assert rst during BUSY of job (9,9) with 2 pairs queued → all outputs 0 and op_rdy=1 immediately (async). After release, the late Multiplier result is never presented; a new push (2,3) → out_res=6.
- Randomised soak: 1000 random pairs with random out_rdy and a golden queue → every out_res == out_a*out_b, order preserved, mul_vld never high outside ISSUE.
